// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, candidate encoding and FSM states
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned NUM_KEYS  = NUM_LINES * NUM_LINES;

    // Candidate is {none, code}; the none flag sits above the 4-bit key index
    typedef logic [4:0] cand_t;

    localparam cand_t KEY_NONE = 5'b1_0000;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } kp_state_e;

    // Collapse a full scan image (active-low) to one key, or NONE when
    // zero keys or more than one key (possible ghost) are seen.
    function automatic cand_t encode_cand(input logic [NUM_KEYS-1:0] bits);
        int unsigned hits;
        logic [3:0]  idx;
        hits = 0;
        idx  = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!bits[i]) begin
                hits++;
                idx = 4'(i);
            end
        end
        return (hits == 1) ? {1'b0, idx} : KEY_NONE;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts identical consecutive scan candidates and
// runs the RELEASED/PRESSED FSM that produces the key outputs.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done_i,
    input  cand_t      cand_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

    cand_t      cand_q,   cand_d;
    logic [3:0] stable_q, stable_d;

    kp_state_e  state_q,  state_d;
    logic [3:0] code_q,   code_d;
    logic       valid_q,  valid_d;

    logic       settled;

    assign settled = (stable_q == STABLE_MAX);

    // Track the latest candidate and how many scans in a row produced it
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        if (scan_done_i) begin
            if (cand_i == cand_q) begin
                if (stable_q != STABLE_MAX) begin
                    stable_d = stable_q + 4'd1;
                end
            end else begin
                cand_d   = cand_i;
                stable_d = 4'd1;
            end
        end
    end

    // Press/release/roll-over decisions; a key already reported is not repeated
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (settled && !cand_q[4]) begin
                    state_d = PRESSED;
                    code_d  = cand_q[3:0];
                    valid_d = 1'b1;
                end
            end
            PRESSED: begin
                if (settled) begin
                    if (cand_q[4]) begin
                        state_d = RELEASED;
                    end else if (cand_q[3:0] != code_q) begin
                        code_d  = cand_q[3:0];
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // Debounce counters and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q   <= KEY_NONE;
            stable_q <= 4'd0;
            state_q  <= RELEASED;
            code_q   <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = (state_q == PRESSED);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: drives one keypad row low at a time, samples the columns
// into a scan image and hands a per-scan candidate to the debouncer.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]          sync1_q, sync2_q;
    logic [DIV_W-1:0]    div_q,   div_d;
    logic [1:0]          row_q,   row_d;
    logic [NUM_KEYS-1:0] scan_q,  scan_d;
    logic                done_q,  done_d;
    logic                sample;
    cand_t               cand;

    // The last cycle of each row period is the sample point
    assign sample = (div_q == DIV_LAST);

    // Divider, row advance, scan image capture and end-of-scan strobe
    always_comb begin
        div_d  = div_q + DIV_W'(1);
        row_d  = row_q;
        scan_d = scan_q;
        done_d = 1'b0;
        if (sample) begin
            div_d = '0;
            row_d = row_q + 2'd1;
            scan_d[{row_q, 2'b00} +: 4] = sync2_q;
            done_d = (row_q == 2'd3);
        end
    end

    // Column synchronizer and scan state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            div_q   <= '0;
            row_q   <= 2'd0;
            scan_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= col_in;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            done_q  <= done_d;
        end
    end

    assign row_out = ~(4'b0001 << row_q);

    // Scan image is complete when done_q is seen, so the encoder reads it directly
    assign cand = encode_cand(scan_q);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .scan_done_i(done_q),
        .cand_i     (cand),
        .key_code_o (key_code),
        .key_valid_o(key_valid),
        .key_held_o (key_held)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model, scan-level reference model and
// a scoreboard monitor for keypad_scan.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    typedef struct {
        int cyc;
        bit valid;
        bit held;
        int code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    int   hist[$];
    int   scan_n = 0;
    bit   m_held = 1'b0;
    int   m_code = 0;

    logic [3:0] exp_row;
    exp_t       mon_e;

    keypad_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the timing reference for expectations
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Matrix model: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int cand_of(input logic [15:0] m);
        if ($countones(m) != 1) return -1;
        for (int k = 0; k < 16; k++) begin
            if (m[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [15:0] key(input int idx);
        logic [15:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] rand_mask();
        int unsigned sel, a, b;
        logic [15:0] m;
        m   = '0;
        sel = $urandom_range(0, 9);
        if (sel >= 4) begin
            a = $urandom_range(0, 15);
            m[a] = 1'b1;
            if (sel == 9) begin
                b = (a + $urandom_range(1, 15)) % 16;
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // Reference: a press/release is accepted once the last DB scans agree
    task automatic model_step(input logic [15:0] m);
        int   c;
        int   run;
        exp_t e;
        c = cand_of(m);
        hist.push_back(c);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != c) break;
            run++;
        end
        e.valid = 1'b0;
        if (run >= DB) begin
            if (c >= 0 && (!m_held || c != m_code)) begin
                e.valid = 1'b1;
                m_held  = 1'b1;
                m_code  = c;
            end else if (c < 0) begin
                m_held = 1'b0;
            end
        end
        e.cyc  = SCAN_CYC * scan_n + SCAN_CYC + 2;
        e.held = m_held;
        e.code = m_code;
        exp_q.push_back(e);
        scan_n++;
    endtask

    task automatic do_scan(input logic [15:0] m);
        pressed = m;
        model_step(m);
        repeat (SCAN_CYC) @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] m, input int n);
        repeat (n) do_scan(m);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row_out"},   32'(row_out),   32'(4'b1110));
        check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_key_held"},  32'(key_held),  32'd0);
        check({tag, "_key_code"},  32'(key_code),  32'd0);
    endtask

    // Monitor: row sweep every cycle, scoreboard pop at each scan's output slot
    always @(negedge clk) begin
        if (rst) begin
            exp_row = 4'hF;
            exp_row[(cyc / SCAN_DIV) % 4] = 1'b0;
            check("row_out", 32'(row_out), 32'(exp_row));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                check("key_valid", 32'(key_valid), 32'(mon_e.valid));
                check("key_held",  32'(key_held),  32'(mon_e.held));
                check("key_code",  32'(key_code),  32'(mon_e.code));
            end else begin
                check("stray_valid", 32'(key_valid), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        #2 rst = 1'b1;

        hold('0, 3);
        hold(key(6), 4);
        hold('0, 3);
        for (int i = 0; i < 6; i++) begin
            do_scan((i % 2 == 0) ? key(6) : 16'h0000);
        end
        hold(key(6), 3);
        hold(key(6) | key(9), 3);
        hold('0, 2);
        hold(key(3), 3);
        hold(key(12), 3);
        for (int i = 0; i < 14; i++) begin
            hold(rand_mask(), $urandom_range(1, 3));
        end
        hold(key(3), 3);

        repeat (6) @(negedge clk);
        check("drained_before_reset", 32'(exp_q.size()), 32'd0);
        #2 rst = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        exp_q.delete();
        hist.delete();
        scan_n  = 0;
        m_held  = 1'b0;
        m_code  = 0;
        pressed = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("held_reset");
        #2 rst = 1'b1;

        hold(key(5), 3);
        hold('0, 3);
        repeat (4) @(negedge clk);
        check("drained_at_end", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
